mii_tx_framer: RTL and testbench

- Store-and-forward frame source directly upstream of mii_tx, in the tx_clk domain.
- Accepts frame bytes (no preamble, no FCS) on a valid/ready byte stream and buffers whole frames.
- Pads short frames and drives mii_tx's sof/ack and byte/eof handshake so mii_tx never underruns mid-frame.

---
 rtl/eth_tx_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/mii_tx_framer.sv | 219 +++++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types for the MII transmit path: framer FSM states, frame length limits, length type.
// No logic of its own; the helper below is evaluated combinationally by its callers.
// No flow control lives here.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SOF,
        S_SEND,
        S_EOF
    } tx_state_t;

    localparam int C_MIN_FRAME_LEN = 60;
    localparam int C_MAX_FRAME_LEN = 1514;

    // Frame byte count, wide enough for any frame up to 2047 bytes
    typedef logic [10:0] len_t;

    // Number of bytes put on the wire for a stored frame of length len
    function automatic len_t send_length(input len_t len, input len_t min_len, input logic pad_en);
        return (pad_en && (len < min_len)) ? min_len : len;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with show-ahead output (dout is the head entry whenever !empty).
// Latency: a pushed entry is visible at dout the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty; push+pop in one cycle is allowed.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;

    assign dout  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // Head/tail pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mii_tx_framer.sv
// Store-and-forward frame buffer feeding mii_tx; optional short-frame padding under TX_FRAMER_PAD_EN.
// Latency: tx_sof rises 2 cycles after the edge committing a frame's last byte (read side idle).
// Backpressure: s_rdy low when the byte buffer is full or the length FIFO is full; tx side follows mii_tx acks/rdy.
module mii_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int BUF_DEPTH = 2048,
    parameter int LEN_DEPTH = 4,
    parameter int MAX_LEN   = C_MAX_FRAME_LEN,
    parameter int MIN_LEN   = C_MIN_FRAME_LEN
) (
    input  logic        tx_clk,
    input  logic        tx_rst,
    input  logic [7:0]  s_byte,
    input  logic        s_vld,
    input  logic        s_last,
    input  logic        s_err,
    output logic        s_rdy,
    output logic        tx_sof,
    input  logic        tx_sof_ack,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_vld,
    input  logic        tx_byte_rdy,
    output logic        tx_eof,
    output logic [15:0] frames_sent,
    output logic [15:0] frames_dropped
);

    localparam int AW = $clog2(BUF_DEPTH);

`ifdef TX_FRAMER_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    localparam len_t        MAX_L    = len_t'(MAX_LEN);
    localparam len_t        MIN_L    = len_t'(MIN_LEN);
    localparam len_t        LEN_ONE  = len_t'(1);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(BUF_DEPTH);

    logic [7:0]  mem [BUF_DEPTH];
    logic [7:0]  rd_dat;

    // Pointers carry one extra bit so a full buffer is distinguishable from an empty one
    logic [AW:0] wr_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] buf_level;

    len_t        wr_len;
    logic        over;
    logic        rst_done;
    logic        acc;
    logic        at_limit;
    logic        drop;
    logic        mem_we;

    logic        len_push;
    logic        len_pop;
    logic        len_empty;
    logic        len_full;
    len_t        len_dout;

    tx_state_t   state;
    len_t        stored_len;
    len_t        send_len;
    len_t        idx;
    len_t        rd_cnt;
    logic        rdy_d;
    logic        ram_re;

    // Space is counted against rd_ptr, so bytes already handed out are reusable
    assign buf_level = wr_ptr - rd_ptr;
    assign s_rdy     = rst_done && (buf_level != FULL_LVL) && !len_full;
    assign acc       = s_vld && s_rdy;

    // A byte arriving when MAX_LEN bytes are already stored makes the frame oversize
    assign at_limit  = over || (wr_len == MAX_L);
    assign drop      = acc && s_last && (s_err || at_limit);
    assign len_push  = acc && s_last && !s_err && !at_limit;
    assign mem_we    = acc && !at_limit;

    assign len_pop   = (state == S_IDLE) && !len_empty;
    assign ram_re    = len_pop ||
                       ((state == S_SEND) && tx_byte_rdy && (rd_cnt < stored_len));

    sync_fifo #(
        .WIDTH ($bits(len_t)),
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk   (tx_clk),
        .rst   (tx_rst),
        .push  (len_push),
        .din   (wr_len + LEN_ONE),
        .pop   (len_pop),
        .dout  (len_dout),
        .empty (len_empty),
        .full  (len_full)
    );

    // Byte buffer write port
    always_ff @(posedge tx_clk) begin
        if (mem_we) begin
            mem[wr_ptr[AW-1:0]] <= s_byte;
        end
    end

    // Byte buffer read port, one-cycle synchronous read
    always_ff @(posedge tx_clk) begin
        if (ram_re) begin
            rd_dat <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Write side: accept bytes, commit good frames, rewind dropped ones
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            rst_done       <= 1'b0;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            wr_len         <= '0;
            over           <= 1'b0;
            frames_dropped <= '0;
        end else begin
            rst_done <= 1'b1;
            if (acc) begin
                if (s_last) begin
                    wr_len <= '0;
                    over   <= 1'b0;
                    if (drop) begin
                        wr_ptr         <= commit_ptr;
                        frames_dropped <= frames_dropped + 16'd1;
                    end else begin
                        wr_ptr     <= wr_ptr + PTR_ONE;
                        commit_ptr <= wr_ptr + PTR_ONE;
                    end
                end else if (at_limit) begin
                    over <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    wr_len <= wr_len + LEN_ONE;
                end
            end
        end
    end

    // Read side: pop a committed frame, request start, walk bytes on mii_tx's nibble cadence
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state       <= S_IDLE;
            rd_ptr      <= '0;
            stored_len  <= '0;
            send_len    <= '0;
            idx         <= '0;
            rd_cnt      <= '0;
            rdy_d       <= 1'b0;
            tx_sof      <= 1'b0;
            tx_byte     <= '0;
            tx_byte_vld <= 1'b0;
            tx_eof      <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!len_empty) begin
                        stored_len <= len_dout;
                        send_len   <= send_length(len_dout, MIN_L, PAD_EN);
                        rd_ptr     <= rd_ptr + PTR_ONE;
                        rd_cnt     <= LEN_ONE;
                        idx        <= '0;
                        state      <= S_SOF;
                    end
                end
                S_SOF: begin
                    // First cycle loads byte 0 from the RAM; then hold until mii_tx acks
                    if (!tx_sof) begin
                        tx_sof      <= 1'b1;
                        tx_byte_vld <= 1'b1;
                        tx_byte     <= rd_dat;
                    end else if (tx_sof_ack) begin
                        tx_sof <= 1'b0;
                        rdy_d  <= 1'b0;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    rdy_d <= tx_byte_rdy;
                    // Prefetch the next stored byte while mii_tx sends the low nibble
                    if (tx_byte_rdy && (rd_cnt < stored_len)) begin
                        rd_ptr <= rd_ptr + PTR_ONE;
                        rd_cnt <= rd_cnt + LEN_ONE;
                    end
                    // Advance only after the high-nibble cycle so tx_byte is stable for both halves
                    if (rdy_d) begin
                        if (idx == send_len - LEN_ONE) begin
                            tx_byte_vld <= 1'b0;
                            tx_eof      <= 1'b1;
                            state       <= S_EOF;
                        end else begin
                            idx     <= idx + LEN_ONE;
                            tx_byte <= ((idx + LEN_ONE) < stored_len) ? rd_dat : 8'h00;
                        end
                    end
                end
                S_EOF: begin
                    tx_eof      <= 1'b0;
                    frames_sent <= frames_sent + 16'd1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer with a small behavioural mii_tx attached.
// The mii_tx model acks tx_sof, sends a short preamble, takes each byte over two nibble cycles, then an IFG.
// Frames are captured from the nibble stream and compared against bench-computed expectations.
module tb_mii_tx_framer;

`ifdef TX_FRAMER_PAD_EN
    localparam int PAD_ON = 1;
`else
    localparam int PAD_ON = 0;
`endif

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [7:0]  s_byte;
    logic        s_vld;
    logic        s_last;
    logic        s_err;
    logic        s_rdy;
    logic        tx_sof;
    logic        tx_sof_ack;
    logic [7:0]  tx_byte;
    logic        tx_byte_vld;
    logic        tx_byte_rdy;
    logic        tx_eof;
    logic [15:0] frames_sent;
    logic [15:0] frames_dropped;

    int total = 0;
    int bad   = 0;

    always #5 tx_clk = ~tx_clk;

    mii_tx_framer dut (
        .tx_clk         (tx_clk),
        .tx_rst         (tx_rst),
        .s_byte         (s_byte),
        .s_vld          (s_vld),
        .s_last         (s_last),
        .s_err          (s_err),
        .s_rdy          (s_rdy),
        .tx_sof         (tx_sof),
        .tx_sof_ack     (tx_sof_ack),
        .tx_byte        (tx_byte),
        .tx_byte_vld    (tx_byte_vld),
        .tx_byte_rdy    (tx_byte_rdy),
        .tx_eof         (tx_eof),
        .frames_sent    (frames_sent),
        .frames_dropped (frames_dropped)
    );

    // ---------------- mii_tx behavioural model ----------------
    typedef enum int {M_IDLE, M_PRE, M_LO, M_HI, M_IFG} mstate_t;
    mstate_t    ms;
    int         mcnt;
    int         cur_len;
    logic       ack_en;
    logic [7:0] lo_byte;
    logic [7:0] cap[$];
    int         cap_len[$];
    int         eof_cnt   = 0;
    int         unstable  = 0;
    int         vld_low   = 0;

    assign tx_sof_ack  = (ms == M_IDLE) && tx_sof && ack_en && !tx_rst;
    assign tx_byte_rdy = (ms == M_LO) && !tx_eof;

    always @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            ms      <= M_IDLE;
            mcnt    <= 0;
            cur_len <= 0;
        end else begin
            case (ms)
                M_IDLE: if (tx_sof_ack) begin ms <= M_PRE; mcnt <= 8; cur_len <= 0; end
                M_PRE:  if (mcnt == 1) ms <= M_LO; else mcnt <= mcnt - 1;
                M_LO: begin
                    if (tx_eof) begin
                        cap_len.push_back(cur_len);
                        ms   <= M_IFG;
                        mcnt <= 12;
                    end else begin
                        lo_byte <= tx_byte;
                        ms      <= M_HI;
                        if (!tx_byte_vld) vld_low = vld_low + 1;
                    end
                end
                M_HI: begin
                    cap.push_back({tx_byte[7:4], lo_byte[3:0]});
                    if (tx_byte != lo_byte) unstable = unstable + 1;
                    cur_len <= cur_len + 1;
                    ms      <= M_LO;
                end
                M_IFG:  if (mcnt == 1) ms <= M_IDLE; else mcnt <= mcnt - 1;
                default: ms <= M_IDLE;
            endcase
        end
    end

    always @(posedge tx_clk) begin
        if (tx_eof) eof_cnt = eof_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Called at a negedge; returns at the negedge just after the last byte's accept edge
    task automatic send_frame(input int len, input int base, input bit err);
        int n;
        for (int i = 0; i < len; i++) begin
            s_vld  = 1'b1;
            s_byte = 8'(base + i);
            s_last = (i == len - 1);
            s_err  = err && (i == len - 1);
            n = 0;
            while (!s_rdy && n < 5000) begin
                @(negedge tx_clk);
                n++;
            end
            if (n >= 5000) begin
                chk("s_rdy timeout", 0, 1);
                break;
            end
            @(negedge tx_clk);
        end
        s_vld  = 1'b0;
        s_last = 1'b0;
        s_err  = 1'b0;
    endtask

    // Waits for the next captured frame and checks its length, contents and FCS
    task automatic expect_frame(input int len, input int base, input int exp_len, input string nm);
        int n;
        int wrong;
        int got;
        logic [7:0]  eb;
        logic [31:0] crc_g;
        logic [31:0] crc_e;
        n = 0;
        while (cap_len.size() == 0 && n < 8 * exp_len + 400) begin
            @(negedge tx_clk);
            n++;
        end
        if (cap_len.size() == 0) begin
            chk({nm, " frame timeout"}, 0, 1);
        end else begin
            got = cap_len.pop_front();
            chk({nm, " length"}, got, exp_len);
            wrong = 0;
            crc_g = 32'hFFFF_FFFF;
            crc_e = 32'hFFFF_FFFF;
            for (int i = 0; i < exp_len; i++) begin
                eb    = (i < len) ? 8'(base + i) : 8'h00;
                crc_e = crc_upd(crc_e, eb);
            end
            for (int i = 0; i < got; i++) begin
                eb = (i < len) ? 8'(base + i) : 8'h00;
                if (cap.size() == 0) begin
                    wrong++;
                end else begin
                    if (cap[0] != eb) wrong++;
                    crc_g = crc_upd(crc_g, cap[0]);
                    void'(cap.pop_front());
                end
            end
            chk({nm, " bytes"}, wrong, 0);
            chk({nm, " fcs"}, int'(~crc_g), int'(~crc_e));
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int len;
        int base;
        bit err;
        int exp_len;   // 0: frame must be dropped
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int exp_sent;
    int exp_drop;
    int eof_base;
    int n;

    initial begin
        vecs[0] = '{10,   'hA0, 1'b0, (PAD_ON != 0) ? 60 : 10};
        vecs[1] = '{20,   'h30, 1'b1, 0};
        vecs[2] = '{64,   'h00, 1'b0, 64};
        vecs[3] = '{1600, 'h55, 1'b0, 0};
        vecs[4] = '{100,  'h10, 1'b0, 100};
        vecs[5] = '{60,   'h80, 1'b0, 60};
        vecs[6] = '{59,   'hC0, 1'b0, (PAD_ON != 0) ? 60 : 59};
        vecs[7] = '{1514, 'h01, 1'b0, 1514};
        vecs[8] = '{1515, 'h02, 1'b0, 0};
        vecs[9] = '{1,    'h7E, 1'b0, (PAD_ON != 0) ? 60 : 1};

        tx_rst = 1'b1;
        s_vld  = 1'b0;
        s_byte = 8'h00;
        s_last = 1'b0;
        s_err  = 1'b0;
        ack_en = 1'b0;

        // Reset state
        repeat (3) @(negedge tx_clk);
        chk("rst s_rdy", s_rdy, 0);
        chk("rst tx_sof", tx_sof, 0);
        chk("rst tx_byte_vld", tx_byte_vld, 0);
        chk("rst tx_byte", tx_byte, 0);
        chk("rst tx_eof", tx_eof, 0);
        chk("rst frames_sent", frames_sent, 0);
        chk("rst frames_dropped", frames_dropped, 0);
        tx_rst = 1'b0;
        chk("s_rdy at release", s_rdy, 0);
        @(negedge tx_clk);
        chk("s_rdy after release", s_rdy, 1);

        // 64-byte frame with mii_tx holding off its ack
        send_frame(64, 'h00, 1'b0);
        chk("sof +0", tx_sof, 0);
        @(negedge tx_clk);
        chk("sof +1", tx_sof, 0);
        @(negedge tx_clk);
        chk("sof +2", tx_sof, 1);
        repeat (20) @(negedge tx_clk);
        chk("sof held", tx_sof, 1);
        chk("byte0 vld held", tx_byte_vld, 1);
        chk("byte0 value", tx_byte, 8'h00);
        ack_en = 1'b1;
        expect_frame(64, 'h00, 64, "f64");
        chk("f64 frames_sent", frames_sent, 1);
        chk("f64 eof count", eof_cnt, 1);
        exp_sent = 1;
        exp_drop = 0;

        // Table-driven frames
        for (int v = 0; v < NV; v++) begin
            send_frame(vecs[v].len, vecs[v].base, vecs[v].err);
            if (vecs[v].exp_len != 0) begin
                exp_sent++;
                expect_frame(vecs[v].len, vecs[v].base, vecs[v].exp_len, $sformatf("vec%0d", v));
            end else begin
                exp_drop++;
                repeat (6) @(negedge tx_clk);
                chk($sformatf("vec%0d no sof", v), tx_sof, 0);
                chk($sformatf("vec%0d no frame", v), cap_len.size(), 0);
            end
            repeat (2) @(negedge tx_clk);
            chk($sformatf("vec%0d frames_sent", v), frames_sent, exp_sent);
            chk($sformatf("vec%0d frames_dropped", v), frames_dropped, exp_drop);
            chk($sformatf("vec%0d eof count", v), eof_cnt, exp_sent);
            chk($sformatf("vec%0d buf level", v), dut.buf_level, 0);
        end

        // Five frames queued while mii_tx refuses to start
        ack_en = 1'b0;
        for (int k = 0; k < 5; k++) send_frame(64, 16 * k + 3, 1'b0);
        chk("stall s_rdy low", s_rdy, 0);
        ack_en = 1'b1;
        for (int k = 0; k < 5; k++) expect_frame(64, 16 * k + 3, 64, $sformatf("stall%0d", k));
        repeat (2) @(negedge tx_clk);
        exp_sent += 5;
        chk("stall frames_sent", frames_sent, exp_sent);
        chk("stall s_rdy back", s_rdy, 1);

        // Reset in the middle of byte 20
        send_frame(64, 'h20, 1'b0);
        n = 0;
        while (cap.size() < 20 && n < 1000) begin
            @(negedge tx_clk);
            n++;
        end
        chk("reach byte 20", (cap.size() >= 20) ? 1 : 0, 1);
        chk("mid-frame vld", tx_byte_vld, 1);
        #2 tx_rst = 1'b1;
        #1;
        chk("async s_rdy", s_rdy, 0);
        chk("async tx_sof", tx_sof, 0);
        chk("async tx_byte_vld", tx_byte_vld, 0);
        chk("async tx_byte", tx_byte, 0);
        chk("async tx_eof", tx_eof, 0);
        chk("async frames_sent", frames_sent, 0);
        chk("async frames_dropped", frames_dropped, 0);
        cap.delete();
        cap_len.delete();
        @(negedge tx_clk);
        tx_rst = 1'b0;
        repeat (2) @(negedge tx_clk);
        chk("post-rst level", dut.buf_level, 0);
        chk("post-rst no frame", cap_len.size(), 0);
        eof_base = eof_cnt;
        send_frame(64, 'h40, 1'b0);
        expect_frame(64, 'h40, 64, "post-rst");
        repeat (2) @(negedge tx_clk);
        chk("post-rst frames_sent", frames_sent, 1);
        chk("post-rst eof count", eof_cnt - eof_base, 1);

        chk("tx_byte stable over nibbles", unstable, 0);
        chk("tx_byte_vld during bytes", vld_low, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
